// File: rtl/pos_controller_p_pkg.sv
// Shared types and constants for the sequential proportional position controller.
// Angle constants are derived from the fractional width so the core can be re-scaled.
package pos_controller_p_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StErr  = 3'd1,
        StMulX = 3'd2,
        StMulY = 3'd3,
        StMulT = 3'd4,
        StSat  = 3'd5
    } state_e;

    localparam int VMAX_DEF  = 32768;
    localparam int WMAX_DEF  = 65536;
    localparam int DB_XY_DEF = 328;
    localparam int DB_TH_DEF = 328;

    // pi scaled by 2^30; rescaled with round-to-nearest for any q up to 29
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic longint pi_fix(input int unsigned q);
        return (PI_Q30 + (64'sd1 <<< (29 - q))) >>> (30 - q);
    endfunction

    function automatic longint two_pi_fix(input int unsigned q);
        return ((2 * PI_Q30) + (64'sd1 <<< (29 - q))) >>> (30 - q);
    endfunction

endpackage

// File: rtl/pos_controller_p_fix_mul_sat.sv
// Combinational signed multiply, arithmetic shift by the fractional width and
// symmetric clamp to a runtime limit (limit must be non-negative).
module fix_mul_sat
    import pos_controller_p_pkg::*;
#(
    parameter int unsigned N_WIDTH = 32,
    parameter int unsigned Q_WIDTH = 15
) (
    input  logic signed [N_WIDTH-1:0] a_i,
    input  logic signed [N_WIDTH-1:0] b_i,
    input  logic signed [N_WIDTH-1:0] lim_i,
    output logic signed [N_WIDTH-1:0] y_o
);

    logic signed [2*N_WIDTH-1:0] prod;
    logic signed [2*N_WIDTH-1:0] shf;
    logic signed [2*N_WIDTH-1:0] lim_w;

    always_comb begin
        prod  = (2*N_WIDTH)'(a_i) * (2*N_WIDTH)'(b_i);
        shf   = prod >>> Q_WIDTH;
        lim_w = (2*N_WIDTH)'(lim_i);
        if (shf > lim_w) begin
            y_o = lim_i;
        end else if (shf < -lim_w) begin
            y_o = -lim_i;
        end else begin
            y_o = shf[N_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pos_controller_p.sv
// Sequential P position controller: latches poses, wraps/deadbands errors, then runs
// x, y and theta through one shared multiply-saturate unit before publishing commands.
module pos_controller_p
    import pos_controller_p_pkg::*;
#(
    parameter int unsigned N_WIDTH = 32,
    parameter int unsigned Q_WIDTH = 15,
    parameter int          VMAX    = VMAX_DEF,
    parameter int          WMAX    = WMAX_DEF,
    parameter int          DB_XY   = DB_XY_DEF,
    parameter int          DB_TH   = DB_TH_DEF
) (
    input  logic                      POS_CONTROLLER_P_CLOCK_50,
    input  logic                      POS_CONTROLLER_P_RESET_InHigh,
    input  logic                      POS_CONTROLLER_P_START_In,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_TARGETX_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_TARGETY_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_TARGETTHETA_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_CURRENTX_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_CURRENTY_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_CURRENTTHETA_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_KPXY_InBus,
    input  logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_KPTHETA_InBus,
    output logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_VX_OutBus,
    output logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_VY_OutBus,
    output logic signed [N_WIDTH-1:0] POS_CONTROLLER_P_WZ_OutBus,
    output logic                      POS_CONTROLLER_P_BUSY_Out,
    output logic                      POS_CONTROLLER_P_DONE_Out,
    output logic                      POS_CONTROLLER_P_ATTARGET_Out
);

    localparam logic signed [N_WIDTH:0]   PiFix    = (N_WIDTH+1)'(pi_fix(Q_WIDTH));
    localparam logic signed [N_WIDTH:0]   TwoPiFix = (N_WIDTH+1)'(two_pi_fix(Q_WIDTH));
    localparam logic signed [N_WIDTH:0]   DbXy     = (N_WIDTH+1)'(DB_XY);
    localparam logic signed [N_WIDTH:0]   DbTh     = (N_WIDTH+1)'(DB_TH);
    localparam logic signed [N_WIDTH-1:0] VmaxL    = N_WIDTH'(VMAX);
    localparam logic signed [N_WIDTH-1:0] WmaxL    = N_WIDTH'(WMAX);

    state_e state_q;
    logic   acc_q;

    logic signed [N_WIDTH-1:0] tx_q, ty_q, tth_q, cx_q, cy_q, cth_q, kxy_q, kth_q;
    logic signed [N_WIDTH-1:0] ex_q, ey_q, eth_q;
    logic signed [N_WIDTH-1:0] hold_x_q, hold_y_q, hold_t_q;
    logic signed [N_WIDTH-1:0] vx_q, vy_q, wz_q;
    logic                      at_next_q, at_q, done_q;

    logic signed [N_WIDTH:0]   dx, dy, dth, dth_w;
    logic signed [N_WIDTH-1:0] ex_sat, ey_sat;
    logic signed [N_WIDTH-1:0] ex_d, ey_d, eth_d;
    logic signed [N_WIDTH-1:0] mul_a, mul_b, mul_lim, mul_y;

    function automatic logic signed [N_WIDTH-1:0] sat_n(input logic signed [N_WIDTH:0] v);
        if (v[N_WIDTH] != v[N_WIDTH-1]) begin
            return v[N_WIDTH] ? {1'b1, {(N_WIDTH-1){1'b0}}} : {1'b0, {(N_WIDTH-1){1'b1}}};
        end
        return v[N_WIDTH-1:0];
    endfunction

    function automatic logic in_db(input logic signed [N_WIDTH:0] v,
                                   input logic signed [N_WIDTH:0] db);
        return (v <= db) && (v >= -db);
    endfunction

    always_comb begin
        dx     = {tx_q[N_WIDTH-1], tx_q} - {cx_q[N_WIDTH-1], cx_q};
        dy     = {ty_q[N_WIDTH-1], ty_q} - {cy_q[N_WIDTH-1], cy_q};
        dth    = {tth_q[N_WIDTH-1], tth_q} - {cth_q[N_WIDTH-1], cth_q};
        ex_sat = sat_n(dx);
        ey_sat = sat_n(dy);
        dth_w  = dth;
        if (dth >= PiFix) begin
            dth_w = dth - TwoPiFix;
        end else if (dth < -PiFix) begin
            dth_w = dth + TwoPiFix;
        end
        ex_d  = in_db({ex_sat[N_WIDTH-1], ex_sat}, DbXy) ? '0 : ex_sat;
        ey_d  = in_db({ey_sat[N_WIDTH-1], ey_sat}, DbXy) ? '0 : ey_sat;
        // wrapped angle always fits N_WIDTH, so the low bits are exact
        eth_d = in_db(dth_w, DbTh) ? '0 : dth_w[N_WIDTH-1:0];
    end

    always_comb begin
        mul_a   = ex_q;
        mul_b   = kxy_q;
        mul_lim = VmaxL;
        case (state_q)
            StMulY: begin
                mul_a = ey_q;
            end
            StMulT: begin
                mul_a   = eth_q;
                mul_b   = kth_q;
                mul_lim = WmaxL;
            end
            default: ;
        endcase
    end

    fix_mul_sat #(
        .N_WIDTH (N_WIDTH),
        .Q_WIDTH (Q_WIDTH)
    ) u_fix_mul_sat (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .lim_i (mul_lim),
        .y_o   (mul_y)
    );

    // Operands are captured on the accept edge; the FSM leaves IDLE one edge later.
    always_ff @(posedge POS_CONTROLLER_P_CLOCK_50) begin
        if (POS_CONTROLLER_P_RESET_InHigh) begin
            state_q   <= StIdle;
            acc_q     <= 1'b0;
            tx_q      <= '0;
            ty_q      <= '0;
            tth_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            cth_q     <= '0;
            kxy_q     <= '0;
            kth_q     <= '0;
            ex_q      <= '0;
            ey_q      <= '0;
            eth_q     <= '0;
            hold_x_q  <= '0;
            hold_y_q  <= '0;
            hold_t_q  <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            wz_q      <= '0;
            at_next_q <= 1'b0;
            at_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (acc_q) begin
                        acc_q   <= 1'b0;
                        state_q <= StErr;
                    end else if (POS_CONTROLLER_P_START_In) begin
                        acc_q <= 1'b1;
                        tx_q  <= POS_CONTROLLER_P_TARGETX_InBus;
                        ty_q  <= POS_CONTROLLER_P_TARGETY_InBus;
                        tth_q <= POS_CONTROLLER_P_TARGETTHETA_InBus;
                        cx_q  <= POS_CONTROLLER_P_CURRENTX_InBus;
                        cy_q  <= POS_CONTROLLER_P_CURRENTY_InBus;
                        cth_q <= POS_CONTROLLER_P_CURRENTTHETA_InBus;
                        kxy_q <= POS_CONTROLLER_P_KPXY_InBus;
                        kth_q <= POS_CONTROLLER_P_KPTHETA_InBus;
                    end
                end
                StErr: begin
                    ex_q      <= ex_d;
                    ey_q      <= ey_d;
                    eth_q     <= eth_d;
                    at_next_q <= (ex_d == '0) && (ey_d == '0) && (eth_d == '0);
                    state_q   <= StMulX;
                end
                StMulX: begin
                    hold_x_q <= mul_y;
                    state_q  <= StMulY;
                end
                StMulY: begin
                    hold_y_q <= mul_y;
                    state_q  <= StMulT;
                end
                StMulT: begin
                    hold_t_q <= mul_y;
                    state_q  <= StSat;
                end
                StSat: begin
                    vx_q    <= hold_x_q;
                    vy_q    <= hold_y_q;
                    wz_q    <= hold_t_q;
                    at_q    <= at_next_q;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign POS_CONTROLLER_P_VX_OutBus    = vx_q;
    assign POS_CONTROLLER_P_VY_OutBus    = vy_q;
    assign POS_CONTROLLER_P_WZ_OutBus    = wz_q;
    assign POS_CONTROLLER_P_BUSY_Out     = (state_q != StIdle);
    assign POS_CONTROLLER_P_DONE_Out     = done_q;
    assign POS_CONTROLLER_P_ATTARGET_Out = at_q;

endmodule

// File: tb/tb_pos_controller_p.sv
// Directed bench for pos_controller_p: timing, saturation, wrap, deadband, handshake, reset.
module tb_pos_controller_p;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [31:0] tx, ty, tth, cx, cy, cth, kxy, kth;
    logic signed [31:0] vx, vy, wz;
    logic busy, done, at;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pos_controller_p dut (
        .POS_CONTROLLER_P_CLOCK_50           (clk),
        .POS_CONTROLLER_P_RESET_InHigh       (rst),
        .POS_CONTROLLER_P_START_In           (start),
        .POS_CONTROLLER_P_TARGETX_InBus      (tx),
        .POS_CONTROLLER_P_TARGETY_InBus      (ty),
        .POS_CONTROLLER_P_TARGETTHETA_InBus  (tth),
        .POS_CONTROLLER_P_CURRENTX_InBus     (cx),
        .POS_CONTROLLER_P_CURRENTY_InBus     (cy),
        .POS_CONTROLLER_P_CURRENTTHETA_InBus (cth),
        .POS_CONTROLLER_P_KPXY_InBus         (kxy),
        .POS_CONTROLLER_P_KPTHETA_InBus      (kth),
        .POS_CONTROLLER_P_VX_OutBus          (vx),
        .POS_CONTROLLER_P_VY_OutBus          (vy),
        .POS_CONTROLLER_P_WZ_OutBus          (wz),
        .POS_CONTROLLER_P_BUSY_Out           (busy),
        .POS_CONTROLLER_P_DONE_Out           (done),
        .POS_CONTROLLER_P_ATTARGET_Out       (at)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic signed [31:0] a_tx, a_ty, a_tth, a_cx, a_cy, a_cth,
                          input logic signed [31:0] a_kxy, a_kth);
        tx = a_tx; ty = a_ty; tth = a_tth; cx = a_cx; cy = a_cy; cth = a_cth;
        kxy = a_kxy; kth = a_kth;
    endtask

    // Start at edge 0 and return just after edge 6, when results are valid.
    task automatic run_op();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        tests_run++;
        if ({vx, vy, wz} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_vel: got %0d %0d %0d expected 0 0 0", vx, vy, wz);
        end
        tests_run++;
        if ({busy, done, at} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy/done/at %b expected 000", {busy, done, at});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_x();
        set_in(32768, 0, 0, 0, 0, 0, 16384, 16384);
        start = 1'b1;
        tick();                 // edge 0
        start = 1'b0;
        tick();                 // edge 1
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy_e1: got %b expected 1", busy);
        end
        repeat (4) tick();      // edge 5
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_e5: got %b expected 0", done);
        end
        tick();                 // edge 6
        tests_run++;
        if ({done, busy, at} !== 3'b100) begin
            tests_failed++;
            $display("FAIL basic_flags_e6: got done/busy/at %b expected 100", {done, busy, at});
        end
        tests_run++;
        if (vx !== 32'sd16384 || vy !== 32'sd0 || wz !== 32'sd0) begin
            tests_failed++;
            $display("FAIL basic_vel: got %0d %0d %0d expected 16384 0 0", vx, vy, wz);
        end
        tick();                 // edge 7
        tests_run++;
        if (done !== 1'b0 || vx !== 32'sd16384) begin
            tests_failed++;
            $display("FAIL basic_hold_e7: got done %b vx %0d expected 0 16384", done, vx);
        end
    endtask

    task automatic test_saturation();
        set_in(131072, -131072, 98304, 0, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if (vx !== 32'sd32768 || vy !== -32'sd32768 || wz !== 32'sd65536) begin
            tests_failed++;
            $display("FAIL sat_pos: got %0d %0d %0d expected 32768 -32768 65536", vx, vy, wz);
        end
        set_in(-131072, 131072, -98304, 0, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if (vx !== -32'sd32768 || vy !== 32'sd32768 || wz !== -32'sd65536) begin
            tests_failed++;
            $display("FAIL sat_neg: got %0d %0d %0d expected -32768 32768 -65536", vx, vy, wz);
        end
        // error overflow must saturate positive, not wrap into the deadband
        set_in(32'sh7FFF_FFFF, 0, 0, 32'sh8000_0000, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if (vx !== 32'sd32768 || at !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_overflow: got vx %0d at %b expected 32768 0", vx, at);
        end
        // shift truncates toward minus infinity
        set_in(0, 1000, 0, 1000, 0, 0, 16385, 0);
        run_op();
        tests_run++;
        if (vx !== -32'sd501 || vy !== 32'sd500) begin
            tests_failed++;
            $display("FAIL trunc: got %0d %0d expected -501 500", vx, vy);
        end
    endtask

    task automatic test_wrap();
        set_in(0, 0, 98304, 0, 0, -98304, 0, 32768);
        run_op();
        tests_run++;
        if (wz !== -32'sd9279) begin
            tests_failed++;
            $display("FAIL wrap_pos: got %0d expected -9279", wz);
        end
        set_in(0, 0, -98304, 0, 0, 98304, 0, 32768);
        run_op();
        tests_run++;
        if (wz !== 32'sd9279) begin
            tests_failed++;
            $display("FAIL wrap_neg: got %0d expected 9279", wz);
        end
    endtask

    task automatic test_deadband();
        set_in(200, -300, 100, 0, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if ({vx, vy, wz} !== 96'd0 || at !== 1'b1) begin
            tests_failed++;
            $display("FAIL db_inside: got %0d %0d %0d at %b expected 0 0 0 1", vx, vy, wz, at);
        end
        set_in(400, -300, 100, 0, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if (vx !== 32'sd400 || at !== 1'b0) begin
            tests_failed++;
            $display("FAIL db_outside: got vx %0d at %b expected 400 0", vx, at);
        end
        set_in(328, -328, -328, 0, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if ({vx, vy, wz} !== 96'd0 || at !== 1'b1) begin
            tests_failed++;
            $display("FAIL db_edge: got %0d %0d %0d at %b expected 0 0 0 1", vx, vy, wz, at);
        end
        set_in(329, 0, -329, 0, 0, 0, 32768, 32768);
        run_op();
        tests_run++;
        if (vx !== 32'sd329 || wz !== -32'sd329 || at !== 1'b0) begin
            tests_failed++;
            $display("FAIL db_edge1: got vx %0d wz %0d at %b expected 329 -329 0", vx, wz, at);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] done_seen;
        logic signed [31:0] vx_first, vx_second;
        done_seen = '0;
        vx_first  = '0;
        vx_second = '0;
        set_in(32768, 0, 0, 0, 0, 0, 16384, 16384);
        for (int i = 0; i < 16; i++) begin
            start = (i < 10);
            if (i == 3) tx = 65536;
            tick();             // edge i
            done_seen[i] = done;
            if (i == 6) vx_first = vx;
            if (i == 13) vx_second = vx;
        end
        start = 1'b0;
        tests_run++;
        if (done_seen !== 16'h2040) begin
            tests_failed++;
            $display("FAIL b2b_done: got %h expected 2040", done_seen);
        end
        tests_run++;
        if (vx_first !== 32'sd16384) begin
            tests_failed++;
            $display("FAIL b2b_first: got %0d expected 16384", vx_first);
        end
        tests_run++;
        if (vx_second !== 32'sd32768) begin
            tests_failed++;
            $display("FAIL b2b_second: got %0d expected 32768", vx_second);
        end
    endtask

    task automatic test_reset_midop();
        logic [12:0] done_seen;
        logic [99:0] snap;
        done_seen = '0;
        snap = '1;
        set_in(32768, 0, 0, 0, 0, 0, 16384, 16384);
        for (int i = 0; i < 13; i++) begin
            start = (i == 0) || (i == 5);
            rst   = (i == 3);
            tick();             // edge i
            done_seen[i] = done;
            if (i == 3) snap = {vx, vy, wz, busy, done, at, 1'b0};
            if (i == 11) begin
                tests_run++;
                if (vx !== 32'sd16384 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rst_restart: got vx %0d busy %b expected 16384 0", vx, busy);
                end
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        tests_run++;
        if (snap !== 100'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: got vx %0d vy %0d wz %0d flags %b expected all 0",
                     snap[99:68], snap[67:36], snap[35:4], snap[3:1]);
        end
        tests_run++;
        if (done_seen !== 13'h0800) begin
            tests_failed++;
            $display("FAIL rst_mid_done: got %h expected 0800", done_seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_x();
        test_saturation();
        test_wrap();
        test_deadband();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
